// File: rtl/fp_round16_pipe_pkg.sv
// fp16Pkg: shared types and constants for the binary16 rounding pipeline.
//   fp16n_t  : normalizer output (sign, exp, hidden+frac+G/R/S), 20 bits
//   fp16_t   : packed IEEE binary16, 16 bits
//   fp_rm_t  : rounding-mode encoding carried with each beat
//   stage1_t : per-beat state held between the decide and add/pack stages
//   stage2_t : rounded result plus {underflow, overflow, inexact}
package fp16Pkg;

  localparam int unsigned EMSB = 4;
  localparam int unsigned FMSB = 9;

  localparam logic [EMSB:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } fp_rm_t;

  typedef struct packed {
    logic            sign;
    logic [EMSB:0]   exp;
    logic [FMSB+4:0] sig;   // [13] hidden, [12:3] frac, [2] G, [1] R, [0] S
  } fp16n_t;

  typedef struct packed {
    logic          sign;
    logic [EMSB:0] exp;
    logic [FMSB:0] frac;
  } fp16_t;

  typedef struct packed {
    logic          sign;
    logic [EMSB:0] exp;
    logic [FMSB:0] frac;
    logic          inc;
    logic          ix;
    logic          under;
    logic          special;  // exp all-ones: inf/NaN passes through untouched
  } stage1_t;

  typedef struct packed {
    fp16_t      res;
    logic [2:0] flags;       // {underflow, overflow, inexact}
  } stage2_t;

endpackage

// File: rtl/fp_round16_pipe_decide.sv
// fp_round16_decide: combinational rounding decision.
//   sign, l, g, r, s : sign, result LSB, guard, round, sticky
//   rm               : rounding mode (5-7 behave as RNE)
//   inc              : add one ULP to {exp,frac}
//   ix               : discarded bits were non-zero
module fp_round16_decide
  import fp16Pkg::*;
(
  input  logic       sign,
  input  logic       l,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       ix
);

  always_comb begin
    ix  = g | r | s;
    inc = 1'b0;
    case (rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & ix;
      RUP:     inc = ~sign & ix;
      RMM:     inc = g;
      default: inc = g & (r | s | l);
    endcase
  end

endmodule

// File: rtl/fp_round16_pipe.sv
// fp_round16_pipe: two-stage valid/ready rounding pipeline, FP16N -> binary16.
//   Stage 1 registers the rounding decision, stage 2 registers the added/packed result.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; i (FP16N), under_i, rm sampled on transfer
//   out_valid / out_ready output handshake; o (binary16), flags_o {unf, ovf, inx}
// Optional feature (macro FP_ROUND16_ACC_FLAGS_EN):
//   clear_flags (in), acc_flags (out) - sticky OR of flags over accepted results.
module fp_round16_pipe
  import fp16Pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$bits(fp16n_t)-1:0] i,
  input  logic                      under_i,
  input  logic [2:0]                rm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$bits(fp16_t)-1:0]  o,
  output logic [2:0]                flags_o
`ifdef FP_ROUND16_ACC_FLAGS_EN
  ,
  input  logic                      clear_flags,
  output logic [2:0]                acc_flags
`endif
);

  fp16n_t  in_n;
  logic    unused_hidden;
  logic    dec_inc;
  logic    dec_ix;
  logic    in_special;

  logic    en1;
  logic    en2;

  logic    v1_d, v1_q;
  logic    v2_d, v2_q;
  stage1_t s1_d, s1_q;
  stage2_t s2_d, s2_q;

  logic [EMSB+FMSB+1:0] sum;
  logic                 ovf;

  always_comb begin
    in_n          = fp16n_t'(i);
    // The hidden bit is implied by exp in the packed format.
    unused_hidden = in_n.sig[FMSB+4];
    in_special    = (in_n.exp == EXP_MAX);
  end

  fp_round16_decide u_decide (
    .sign (in_n.sign),
    .l    (in_n.sig[3]),
    .g    (in_n.sig[2]),
    .r    (in_n.sig[1]),
    .s    (in_n.sig[0]),
    .rm   (rm),
    .inc  (dec_inc),
    .ix   (dec_ix)
  );

  // Handshake: a stage advances when it is empty or its successor advances.
  always_comb begin
    en2 = ~v2_q | out_ready;
    en1 = ~v1_q | en2;
  end

  // Stage 1 next state.
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (en1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d.sign    = in_n.sign;
        s1_d.exp     = in_n.exp;
        s1_d.frac    = in_n.sig[FMSB+3:3];
        s1_d.inc     = dec_inc & ~in_special;
        s1_d.ix      = dec_ix & ~in_special;
        s1_d.under   = under_i;
        s1_d.special = in_special;
      end
    end
  end

  // Stage 2: carry out of frac ripples into exp, covering denormal->normal,
  // binade crossing and overflow to inf without special cases.
  always_comb begin
    sum  = {s1_q.exp, s1_q.frac} + {{(EMSB+FMSB+1){1'b0}}, s1_q.inc};
    ovf  = ~s1_q.special & (sum[EMSB+FMSB+1:FMSB+1] == EXP_MAX);
    v2_d = v2_q;
    s2_d = s2_q;
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_d.res   = {s1_q.sign, sum};
        s2_d.flags = {s1_q.under & s1_q.ix, ovf, s1_q.ix | ovf};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_comb begin
    in_ready  = en1;
    out_valid = v2_q;
    o         = s2_q.res;
    flags_o   = s2_q.flags;
  end

`ifdef FP_ROUND16_ACC_FLAGS_EN
  logic [2:0] acc_d, acc_q;

  // Clear and accept in the same cycle keeps the newly accepted flags.
  always_comb begin
    acc_d = (clear_flags ? '0 : acc_q) | ((v2_q & out_ready) ? s2_q.flags : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  always_comb acc_flags = acc_q;
`endif

endmodule

// File: tb/tb_fp_round16_pipe.sv
// Directed self-checking bench for fp_round16_pipe.
module tb_fp_round16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] i;
  logic        under_i;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] o;
  logic [2:0]  flags_o;
`ifdef FP_ROUND16_ACC_FLAGS_EN
  logic        clear_flags;
  logic [2:0]  acc_flags;
  logic        clr_next;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fp_round16_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .under_i   (under_i),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .flags_o   (flags_o)
`ifdef FP_ROUND16_ACC_FLAGS_EN
    ,
    .clear_flags (clear_flags),
    .acc_flags   (acc_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] n;
    logic [2:0]  rm;
    logic        under;
    logic [15:0] exp_o;
    logic [2:0]  exp_f;
  } vec_t;

  function automatic logic [19:0] mk(input logic s, input logic [4:0] e,
                                     input logic [9:0] f, input logic [2:0] grs);
    return {s, e, (e != 5'd0), f, grs};
  endfunction

  function automatic vec_t mkv(input logic [19:0] n, input logic [2:0] r, input logic u,
                               input logic [15:0] eo, input logic [2:0] ef);
    vec_t v;
    v.n = n; v.rm = r; v.under = u; v.exp_o = eo; v.exp_f = ef;
    return v;
  endfunction

  // Presents one beat with out_ready=1 and waits (bounded) for its result.
  task automatic send_one(input logic [19:0] n, input logic [2:0] r, input logic u,
                          output logic [15:0] got_o, output logic [2:0] got_f,
                          output int lat, output bit ok);
    int cyc;
    ok = 1'b0; lat = 0; got_o = 'x; got_f = 'x;
    @(negedge clk);
    i = n; rm = r; under_i = u; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++; #1;
    end
    if (!out_valid) return;
    got_o = o; got_f = flags_o; ok = 1'b1;
`ifdef FP_ROUND16_ACC_FLAGS_EN
    clear_flags = clr_next;
`endif
    @(posedge clk);
    #1;
`ifdef FP_ROUND16_ACC_FLAGS_EN
    clear_flags = 1'b0;
    clr_next    = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (o !== 16'h0000) begin
      n_bad++; $display("FAIL reset_o: got %h want 0000", o);
    end
    n_vec++;
    if (flags_o !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", flags_o);
    end
`ifdef FP_ROUND16_ACC_FLAGS_EN
    n_vec++;
    if (acc_flags !== 3'b000) begin
      n_bad++; $display("FAIL reset_acc: got %b want 000", acc_flags);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_round_vectors;
    vec_t        vt[16];
    logic [15:0] go;
    logic [2:0]  gf;
    int          lat;
    bit          ok;
    vt[0]  = mkv(mk(0, 15, 10'h001, 3'b100), 3'd0, 0, 16'h3C02, 3'b001); // tie, odd -> up
    vt[1]  = mkv(mk(0, 15, 10'h002, 3'b100), 3'd0, 0, 16'h3C02, 3'b001); // tie, even -> stay
    vt[2]  = mkv(mk(0, 15, 10'h3FF, 3'b100), 3'd0, 0, 16'h4000, 3'b001); // frac carry
    vt[3]  = mkv(mk(0, 30, 10'h3FF, 3'b100), 3'd0, 0, 16'h7C00, 3'b011); // overflow RNE
    vt[4]  = mkv(mk(0, 30, 10'h3FF, 3'b100), 3'd1, 0, 16'h7BFF, 3'b001); // RTZ saturate
    vt[5]  = mkv(mk(1, 30, 10'h3FF, 3'b100), 3'd2, 0, 16'hFC00, 3'b011); // RDN neg overflow
    vt[6]  = mkv(mk(0, 0,  10'h3FF, 3'b100), 3'd0, 1, 16'h0400, 3'b101); // denormal -> normal
    vt[7]  = mkv(mk(0, 31, 10'h000, 3'b000), 3'd0, 0, 16'h7C00, 3'b000); // inf pass
    vt[8]  = mkv(mk(0, 31, 10'h000, 3'b111), 3'd3, 0, 16'h7C00, 3'b000); // inf, GRS ignored
    vt[9]  = mkv(mk(1, 0,  10'h000, 3'b000), 3'd0, 0, 16'h8000, 3'b000); // signed zero
    vt[10] = mkv(mk(0, 15, 10'h000, 3'b100), 3'd4, 0, 16'h3C01, 3'b001); // RMM tie away
    vt[11] = mkv(mk(0, 15, 10'h000, 3'b001), 3'd3, 0, 16'h3C01, 3'b001); // RUP pos
    vt[12] = mkv(mk(1, 15, 10'h000, 3'b001), 3'd3, 0, 16'hBC00, 3'b001); // RUP neg
    vt[13] = mkv(mk(1, 15, 10'h000, 3'b001), 3'd2, 0, 16'hBC01, 3'b001); // RDN neg
    vt[14] = mkv(mk(0, 15, 10'h001, 3'b011), 3'd7, 0, 16'h3C01, 3'b001); // mode 7 = RNE, below half
    vt[15] = mkv(mk(0, 0,  10'h100, 3'b000), 3'd0, 1, 16'h0100, 3'b000); // tiny but exact
    for (int k = 0; k < 16; k++) begin
      send_one(vt[k].n, vt[k].rm, vt[k].under, go, gf, lat, ok);
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL vec%0d_timeout: no result within bound", k);
      end else begin
        if (go !== vt[k].exp_o) begin
          n_bad++; $display("FAIL vec%0d_o: got %h want %h", k, go, vt[k].exp_o);
        end
        n_vec++;
        if (gf !== vt[k].exp_f) begin
          n_bad++; $display("FAIL vec%0d_flags: got %b want %b", k, gf, vt[k].exp_f);
        end
      end
    end
  endtask

  task automatic test_latency;
    logic [15:0] go;
    logic [2:0]  gf;
    int          lat;
    bit          ok;
    send_one(mk(0, 16, 10'h155, 3'b000), 3'd0, 0, go, gf, lat, ok);
    n_vec++;
    if (!ok || lat != 2) begin
      n_bad++; $display("FAIL latency: got %0d cycles (ok=%0b) want 2", lat, ok);
    end
    n_vec++;
    if (go !== 16'h4155) begin
      n_bad++; $display("FAIL latency_o: got %h want 4155", go);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] got[$];
    int          sent;
    sent = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      i         = mk(0, 15, 10'(sent + 1), 3'b000);
      rm        = 3'd0;
      under_i   = 1'b0;
      #1;
      if (cyc == 1) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b_ready_one_held: got %b want 1", in_ready);
        end
      end
      if (cyc == 2) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL b2b_ready_two_held: got %b want 0", in_ready);
        end
      end
      if (cyc == 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || o !== 16'h3C01) begin
          n_bad++; $display("FAIL b2b_stall_hold: got v=%b o=%h want v=1 o=3c01", out_valid, o);
        end
      end
      if (out_valid && out_ready) got.push_back(o);
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (got.size() != 5) begin
      n_bad++; $display("FAIL b2b_count: got %0d results want 5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      n_vec++;
      if (got[k] !== 16'h3C01 + 16'(k)) begin
        n_bad++; $display("FAIL b2b_order%0d: got %h want %h", k, got[k], 16'h3C01 + 16'(k));
      end
    end
  endtask

`ifdef FP_ROUND16_ACC_FLAGS_EN
  task automatic test_acc_flags;
    logic [15:0] go;
    logic [2:0]  gf;
    int          lat;
    bit          ok;
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    #1;
    n_vec++;
    if (acc_flags !== 3'b000) begin
      n_bad++; $display("FAIL acc_clear: got %b want 000", acc_flags);
    end
    send_one(mk(0, 30, 10'h3FF, 3'b100), 3'd0, 0, go, gf, lat, ok);
    n_vec++;
    if (acc_flags !== 3'b011) begin
      n_bad++; $display("FAIL acc_ovf: got %b want 011", acc_flags);
    end
    send_one(mk(0, 0, 10'h3FF, 3'b100), 3'd0, 1, go, gf, lat, ok);
    n_vec++;
    if (acc_flags !== 3'b111) begin
      n_bad++; $display("FAIL acc_or: got %b want 111", acc_flags);
    end
    clr_next = 1'b1;
    send_one(mk(0, 15, 10'h000, 3'b010), 3'd0, 0, go, gf, lat, ok);
    n_vec++;
    if (acc_flags !== 3'b001) begin
      n_bad++; $display("FAIL acc_clear_and_xfer: got %b want 001", acc_flags);
    end
  endtask
`endif

  task automatic test_reset_midflight;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    i         = mk(0, 15, 10'h0AA, 3'b111);
    rm        = 3'd0;
    under_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_async_drop: got %b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (flags_o !== 3'b000) begin
      n_bad++; $display("FAIL midrst_flags: got %b want 000", flags_o);
    end
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_handshake: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
`ifdef FP_ROUND16_ACC_FLAGS_EN
    n_vec++;
    if (acc_flags !== 3'b000) begin
      n_bad++; $display("FAIL midrst_acc: got %b want 000", acc_flags);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    i         = '0;
    under_i   = 1'b0;
    rm        = 3'd0;
    out_ready = 1'b1;
`ifdef FP_ROUND16_ACC_FLAGS_EN
    clear_flags = 1'b0;
    clr_next    = 1'b0;
`endif
    test_reset;
    test_round_vectors;
    test_latency;
    test_back_to_back;
`ifdef FP_ROUND16_ACC_FLAGS_EN
    test_acc_flags;
`endif
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
